poly_coeff_sequencer: RTL and testbench

POLY_COEFF_SEQUENCER -- requirements
Module: poly_coeff_sequencer

---
 rtl/poly_coeff_sequencer.sv | 162 ++++++++++++++++
 tb/tb_poly_coeff_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_coeff_sequencer.sv
// Horner-evaluation sequencer: steps an external add/multiply datapath through one polynomial per operand.
// Optional macro SEQ_COEFF_WR_EN turns the constant coefficient table into a register file written while idle.
module poly_coeff_sequencer #(
  parameter int                          WIDTH      = 32,
  parameter int                          NUM_COEFF  = 8,
  parameter int                          STEP_LAT   = 4,
  parameter logic [NUM_COEFF*WIDTH-1:0]  COEFF_INIT = '0
) (
  input  logic             clk_n,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic [WIDTH-1:0] signal,
  output logic [WIDTH-1:0] coeff,
  output logic             LD_result,
  input  logic [WIDTH-1:0] dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef SEQ_COEFF_WR_EN
  ,
  input  logic             coef_wr_en,
  input  logic [3:0]       coef_wr_addr,
  input  logic [WIDTH-1:0] coef_wr_data
`endif
);

  typedef enum logic [2:0] {IDLE, PRIME, STEP, LOAD, CAPTURE, HOLD} state_e;

  localparam logic [3:0] LAT_LAST = 4'(STEP_LAT - 1);
  localparam logic [3:0] N_LAST   = 4'(NUM_COEFF - 1);

  state_e           state_q, state_d;
  logic [3:0]       cyc_q, cyc_d;
  logic [3:0]       step_q, step_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // Sixteen slots so a 4-bit index never leaves the array; slots past NUM_COEFF read as zero.
  logic [WIDTH-1:0] coef_tab [16];

  for (genvar i = 0; i < 16; i++) begin : g_coef
    if (i < NUM_COEFF) begin : g_used
`ifdef SEQ_COEFF_WR_EN
      logic [WIDTH-1:0] coef_q;
      // NOTE: this coefficient file is reset on purpose so reset restores COEFF_INIT; plain storage arrays normally are not.
      always_ff @(negedge clk_n) begin
        if (rst_n) begin
          coef_q <= COEFF_INIT[i*WIDTH +: WIDTH];
        end else if (state_q == IDLE && coef_wr_en && coef_wr_addr == 4'(i)) begin
          coef_q <= coef_wr_data;
        end
      end
      assign coef_tab[i] = coef_q;
`else
      assign coef_tab[i] = COEFF_INIT[i*WIDTH +: WIDTH];
`endif
    end else begin : g_unused
      assign coef_tab[i] = '0;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    step_d     = step_q;
    x_d        = x_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          cyc_d   = '0;
          step_d  = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (cyc_q == LAT_LAST) begin
          cyc_d = '0;
          if (NUM_COEFF == 1) begin
            state_d = LOAD;
          end else begin
            step_d  = 4'd1;
            state_d = STEP;
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      STEP: begin
        if (cyc_q == LAT_LAST) begin
          cyc_d = '0;
          if (step_q == N_LAST) begin
            step_d  = '0;
            state_d = LOAD;
          end else begin
            step_d = step_q + 4'd1;
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      LOAD:    state_d = CAPTURE;
      CAPTURE: begin
        out_data_d = dp_result;
        state_d    = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath drive is decoded from registered state, so it is zero whenever the sequencer is idle.
  always_comb begin
    signal    = '0;
    coeff     = '0;
    LD_result = 1'b0;
    unique case (state_q)
      PRIME: coeff = coef_tab[N_LAST - step_q];
      STEP: begin
        signal = x_q;
        coeff  = coef_tab[N_LAST - step_q];
      end
      LOAD: begin
        signal    = (NUM_COEFF > 1) ? x_q : '0;
        coeff     = coef_tab[0];
        LD_result = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the reset input is active-high despite its name and is sampled on the falling edge like all state;
  // non-blocking assignments make every register load from pre-edge values.
  always_ff @(negedge clk_n) begin
    if (rst_n) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      step_q     <= '0;
      x_q        <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      step_q     <= step_d;
      x_q        <= x_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_poly_coeff_sequencer.sv
// Bench for poly_coeff_sequencer: a real-valued pipelined Horner datapath model per instance and a result scoreboard.
module tb_poly_coeff_sequencer;

  localparam int          N    = 3;
  localparam int          L    = 4;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] B_A0 = 32'h40400000;

  logic clk_n = 1'b1;
  always #5 clk_n = ~clk_n;

  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_ld, a_out_valid, a_out_ready, a_busy;
  logic [31:0] a_in_x, a_signal, a_coeff, a_dp, a_out_data;
  logic        b_in_valid, b_in_ready, b_ld, b_out_valid, b_out_ready, b_busy;
  logic [31:0] b_in_x, b_signal, b_coeff, b_dp, b_out_data;
`ifdef SEQ_COEFF_WR_EN
  logic        a_wr_en, b_wr_en, wr_busy;
  logic [3:0]  a_wr_addr, b_wr_addr;
  logic [31:0] a_wr_data, b_wr_data;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] model_a [N];

  poly_coeff_sequencer #(.WIDTH(32), .NUM_COEFF(N), .STEP_LAT(L), .COEFF_INIT({ONE, ONE, ONE})) u_dut (
    .clk_n(clk_n), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_x(a_in_x),
    .signal(a_signal), .coeff(a_coeff), .LD_result(a_ld), .dp_result(a_dp),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
`ifdef SEQ_COEFF_WR_EN
    , .coef_wr_en(a_wr_en), .coef_wr_addr(a_wr_addr), .coef_wr_data(a_wr_data)
`endif
  );

  poly_coeff_sequencer #(.WIDTH(32), .NUM_COEFF(1), .STEP_LAT(L), .COEFF_INIT(B_A0)) u_one (
    .clk_n(clk_n), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x),
    .signal(b_signal), .coeff(b_coeff), .LD_result(b_ld), .dp_result(b_dp),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy)
`ifdef SEQ_COEFF_WR_EN
    , .coef_wr_en(b_wr_en), .coef_wr_addr(b_wr_addr), .coef_wr_data(b_wr_data)
`endif
  );

  // Normal single-precision values only; zero maps to zero.
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    int          e;
    if (b[30:23] == 8'd0) return 0.0;
    e = int'(b[30:23]) + 896;
    d = {b[31], e[10:0], b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] horner_a(input logic [31:0] x);
    real acc;
    acc = f2r(model_a[N-1]);
    for (int k = 1; k < N; k++) acc = acc * f2r(x) + f2r(model_a[N-1-k]);
    return r2f(acc);
  endfunction

  // Datapath model: an L-deep multiply-add loop (pipe = pipe_out*signal + coeff) and a result register loaded by LD_result.
  real pipe_a [L];
  real pipe_b [L];
  real res_a = 0.0;
  real res_b = 0.0;

  always @(negedge clk_n) begin
    pipe_a[0] <= pipe_a[L-1] * f2r(a_signal) + f2r(a_coeff);
    pipe_b[0] <= pipe_b[L-1] * f2r(b_signal) + f2r(b_coeff);
    for (int i = 1; i < L; i++) begin
      pipe_a[i] <= pipe_a[i-1];
      pipe_b[i] <= pipe_b[i-1];
    end
    if (a_ld) res_a <= pipe_a[L-1];
    if (b_ld) res_b <= pipe_b[L-1];
  end

  assign a_dp = r2f(res_a);
  assign b_dp = r2f(res_b);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One evaluation on the main instance; hold = cycles out_ready stays low once out_valid rises.
  task automatic run_a(input logic [31:0] x, input int hold);
    int          ov_at  = -1;
    int          ld_cnt = 0;
    int          ld_at  = -1;
    logic [31:0] held, exp_s, exp_c;
    a_in_x     = x;
    a_in_valid = 1'b1;
    @(negedge clk_n);
    #1;
    a_in_valid = 1'b0;
`ifdef SEQ_COEFF_WR_EN
    a_wr_en = 1'b0;
`endif
    exp_a.push_back(horner_a(x));
    for (int c = 0; c < 100; c++) begin
      @(posedge clk_n);
      if (c <= N*L) begin
        exp_s = (c < L) ? 32'h0 : x;
        exp_c = (c < N*L) ? model_a[N-1-c/L] : model_a[0];
        check("drive_signal", a_signal, exp_s);
        check("drive_coeff", a_coeff, exp_c);
      end
`ifdef SEQ_COEFF_WR_EN
      if (wr_busy && c == 6) begin
        a_wr_en   = 1'b1;
        a_wr_addr = 4'd1;
        a_wr_data = TWO;
      end else begin
        a_wr_en = 1'b0;
      end
`endif
      if (a_ld) begin
        ld_cnt++;
        ld_at = c;
      end
      if (a_out_valid) begin
        ov_at = c;
        break;
      end
    end
    check("ld_pulses", ld_cnt, 1);
    check("ld_cycle", ld_at, N*L);
    check("latency", ov_at, N*L+2);
    if (ov_at < 0) return;
    check("busy_hold", a_busy, 1'b1);
    held = a_out_data;
    if (hold > 0) begin
      a_in_x     = 32'h3F000000;
      a_in_valid = 1'b1;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_n);
      check("hold_valid", a_out_valid, 1'b1);
      check("hold_data", a_out_data, held);
      check("hold_in_ready", a_in_ready, 1'b0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    check("result", a_out_data, exp_a.pop_front());
    @(negedge clk_n);
    #1;
    a_out_ready = 1'b0;
    @(posedge clk_n);
    check("idle_ready", a_in_ready, 1'b1);
    check("idle_valid", a_out_valid, 1'b0);
    check("idle_data_kept", a_out_data, held);
    check("idle_signal", a_signal, 32'h0);
    check("idle_coeff", a_coeff, 32'h0);
  endtask

  task automatic run_b(input logic [31:0] x);
    int ov_at    = -1;
    int sig_hits = 0;
    b_in_x     = x;
    b_in_valid = 1'b1;
    @(negedge clk_n);
    #1;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    exp_b.push_back(B_A0);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk_n);
      if (b_signal != 32'h0) sig_hits++;
      if (b_out_valid) begin
        ov_at = c;
        break;
      end
    end
    check("b_latency", ov_at, L+2);
    check("b_no_step", sig_hits, 0);
    if (ov_at >= 0) check("b_result", b_out_data, exp_b.pop_front());
    @(negedge clk_n);
    #1;
    b_out_ready = 1'b0;
    @(posedge clk_n);
    check("b_idle_ready", b_in_ready, 1'b1);
  endtask

  initial begin
    bit ld_seen = 1'b0;
    bit ov_seen = 1'b0;
    for (int i = 0; i < N; i++) model_a[i] = ONE;
    a_in_valid = 1'b0; a_in_x = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_x = '0; b_out_ready = 1'b0;
`ifdef SEQ_COEFF_WR_EN
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; wr_busy = 1'b0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
`endif
    rst_n = 1'b1;
    repeat (3) @(negedge clk_n);
    #1 rst_n = 1'b0;
    @(posedge clk_n);
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_data", a_out_data, 32'h0);
    check("rst_signal", a_signal, 32'h0);
    check("rst_coeff", a_coeff, 32'h0);
    check("rst_ld", a_ld, 1'b0);
    check("rst_b_ready", b_in_ready, 1'b1);

    run_a(TWO, 10);
    run_a(32'h40400000, 0);
    run_a(32'h3F000000, 2);
    run_a(32'hBF800000, 0);

    // Abort an evaluation with reset while it is in the first Horner step.
    a_in_x     = 32'h40400000;
    a_in_valid = 1'b1;
    @(negedge clk_n);
    #1 a_in_valid = 1'b0;
    repeat (5) @(negedge clk_n);
    #1 rst_n = 1'b1;
    @(negedge clk_n);
    #1 rst_n = 1'b0;
    @(posedge clk_n);
    check("abort_ready", a_in_ready, 1'b1);
    check("abort_busy", a_busy, 1'b0);
    check("abort_data", a_out_data, 32'h0);
    repeat (20) begin
      @(posedge clk_n);
      ld_seen |= a_ld;
      ov_seen |= a_out_valid;
    end
    check("abort_no_ld", ld_seen, 1'b0);
    check("abort_no_valid", ov_seen, 1'b0);

    run_a(32'h3FC00000, 0);
    run_b(TWO);
    run_b(32'h40A00000);

`ifdef SEQ_COEFF_WR_EN
    wr_busy = 1'b1;
    run_a(TWO, 0);
    wr_busy = 1'b0;
    a_wr_en   = 1'b1;
    a_wr_addr = 4'd3;
    a_wr_data = 32'h41200000;
    @(negedge clk_n);
    #1 a_wr_en = 1'b0;
    a_wr_en    = 1'b1;
    a_wr_addr  = 4'd1;
    a_wr_data  = TWO;
    model_a[1] = TWO;
    run_a(TWO, 0);
    run_a(32'h40400000, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
